// File: rtl/sync_tp_ram_init.sv
// Simple two-port (one write, one read) RAM with byte enables and a
// self-initialising fill sequencer. After reset every word is written
// with INIT_VALUE, one word per cycle, before user traffic is accepted.
module sync_tp_ram_init #(
    parameter int                    ADDR_WIDTH = 10,
    parameter int                    DATA_DEPTH = 1024,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    OUT_REGS   = 0,
    parameter int                    RDW_MODE   = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                      Clk_CI,
    input  logic                      Rst_RI,
    input  logic                      WrEn_SI,
    input  logic [ADDR_WIDTH-1:0]     WrAddr_DI,
    input  logic [DATA_WIDTH-1:0]     WrData_DI,
    input  logic [DATA_WIDTH/8-1:0]   WrBe_DI,
    input  logic                      RdEn_SI,
    input  logic [ADDR_WIDTH-1:0]     RdAddr_DI,
    output logic [DATA_WIDTH-1:0]     RdData_DO,
    output logic                      RdValid_SO,
    output logic                      InitBusy_SO
);

    localparam int BE_WIDTH  = DATA_WIDTH / 8;
    localparam int IDX_WIDTH = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DATA_DEPTH - 1);

    // Reject parameter combinations the datapath cannot honour
    if (DATA_DEPTH < 1 || DATA_DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
        $error("sync_tp_ram_init: DATA_DEPTH must be in 1..2**ADDR_WIDTH");
    end
    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_width
        $error("sync_tp_ram_init: DATA_WIDTH must be a non-zero multiple of 8");
    end
    if (OUT_REGS != 0 && OUT_REGS != 1) begin : g_bad_out_regs
        $error("sync_tp_ram_init: OUT_REGS must be 0 or 1");
    end
    if (RDW_MODE != 0 && RDW_MODE != 1) begin : g_bad_rdw_mode
        $error("sync_tp_ram_init: RDW_MODE must be 0 or 1");
    end

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t                  state_reg;
    logic [ADDR_WIDTH-1:0]   init_cnt_reg;
    logic                    init_busy_reg;

    logic [DATA_WIDTH-1:0]   mem [DATA_DEPTH];

    logic                    wr_in_range;
    logic                    rd_in_range;
    logic [IDX_WIDTH-1:0]    wr_idx;
    logic [IDX_WIDTH-1:0]    rd_idx;

    logic                    mem_we;
    logic [IDX_WIDTH-1:0]    mem_idx;
    logic [BE_WIDTH-1:0]     mem_be;
    logic [DATA_WIDTH-1:0]   mem_wdata;

    logic                    rd_req;
    logic                    wr_hit;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [DATA_WIDTH-1:0]   rd_fwd;
    logic [DATA_WIDTH-1:0]   rd_result;

    logic                    rd_valid1_reg;
    logic [DATA_WIDTH-1:0]   rd_data1_reg;

    assign wr_idx = WrAddr_DI[IDX_WIDTH-1:0];
    assign rd_idx = RdAddr_DI[IDX_WIDTH-1:0];

    // A full power-of-two depth means every address is valid
    if (DATA_DEPTH == (1 << ADDR_WIDTH)) begin : g_full_range
        assign wr_in_range = 1'b1;
        assign rd_in_range = 1'b1;
    end else begin : g_partial_range
        assign wr_in_range = (WrAddr_DI <= LAST_ADDR);
        assign rd_in_range = (RdAddr_DI <= LAST_ADDR);
    end

    // Init sequencer: walk addresses 0..DATA_DEPTH-1, then open for traffic
    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            state_reg     <= ST_INIT;
            init_cnt_reg  <= '0;
            init_busy_reg <= 1'b1;
        end else if (state_reg == ST_INIT) begin
            if (init_cnt_reg == LAST_ADDR) begin
                state_reg     <= ST_READY;
                init_busy_reg <= 1'b0;
            end else begin
                init_cnt_reg <= init_cnt_reg + 1'b1;
            end
        end
    end

    assign InitBusy_SO = init_busy_reg;

    // Single write port shared by the sequencer and user writes
    always_comb begin
        mem_we    = 1'b0;
        mem_idx   = wr_idx;
        mem_be    = WrBe_DI;
        mem_wdata = WrData_DI;
        if (!Rst_RI) begin
            if (state_reg == ST_INIT) begin
                mem_we    = 1'b1;
                mem_idx   = init_cnt_reg[IDX_WIDTH-1:0];
                mem_be    = '1;
                mem_wdata = INIT_VALUE;
            end else if (WrEn_SI && wr_in_range) begin
                mem_we = 1'b1;
            end
        end
    end

    // Byte-masked array write; the array itself is never reset
    always_ff @(posedge Clk_CI) begin
        if (mem_we) begin
            for (int b = 0; b < BE_WIDTH; b++) begin
                if (mem_be[b]) begin
                    mem[mem_idx][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rd_req  = RdEn_SI && (state_reg == ST_READY);
    assign wr_hit  = WrEn_SI && (state_reg == ST_READY) && wr_in_range
                     && (WrAddr_DI == RdAddr_DI);
    assign rd_word = mem[rd_idx];

    // Write-first mode substitutes the bytes being written this cycle
    for (genvar gi = 0; gi < BE_WIDTH; gi++) begin : g_fwd
        assign rd_fwd[gi*8 +: 8] = ((RDW_MODE == 1) && wr_hit && WrBe_DI[gi])
                                   ? WrData_DI[gi*8 +: 8] : rd_word[gi*8 +: 8];
    end

    assign rd_result = rd_in_range ? rd_fwd : '0;

    // First read stage: registered array output, updated only on a read
    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            rd_valid1_reg <= 1'b0;
            rd_data1_reg  <= '0;
        end else begin
            rd_valid1_reg <= rd_req;
            if (rd_req) begin
                rd_data1_reg <= rd_result;
            end
        end
    end

    if (OUT_REGS == 1) begin : g_out_reg
        logic                  rd_valid2_reg;
        logic [DATA_WIDTH-1:0] rd_data2_reg;

        // Optional output stage; holds data between completed reads
        always_ff @(posedge Clk_CI) begin
            if (Rst_RI) begin
                rd_valid2_reg <= 1'b0;
                rd_data2_reg  <= '0;
            end else begin
                rd_valid2_reg <= rd_valid1_reg;
                if (rd_valid1_reg) begin
                    rd_data2_reg <= rd_data1_reg;
                end
            end
        end

        assign RdValid_SO = rd_valid2_reg;
        assign RdData_DO  = rd_data2_reg;
    end else begin : g_no_out_reg
        assign RdValid_SO = rd_valid1_reg;
        assign RdData_DO  = rd_data1_reg;
    end

endmodule

// File: tb/tb_sync_tp_ram_init.sv
// Bench for sync_tp_ram_init: two instances share the stimulus
// (a: OUT_REGS=1 write-first, b: OUT_REGS=0 read-first) and are compared
// every cycle against a word-array reference model.
module tb_sync_tp_ram_init;

    localparam int          AW = 4;
    localparam int          DD = 12;
    localparam int          DW = 32;
    localparam int          BW = 4;
    localparam logic [31:0] IV = 32'hA5A5A5A5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [BW-1:0] wr_be;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data_a, rd_data_b;
    logic          rd_valid_a, rd_valid_b;
    logic          busy_a, busy_b;

    sync_tp_ram_init #(
        .ADDR_WIDTH(AW), .DATA_DEPTH(DD), .DATA_WIDTH(DW),
        .OUT_REGS(1), .RDW_MODE(1), .INIT_VALUE(IV)
    ) dut_a (
        .Clk_CI(clk), .Rst_RI(rst), .WrEn_SI(wr_en), .WrAddr_DI(wr_addr),
        .WrData_DI(wr_data), .WrBe_DI(wr_be), .RdEn_SI(rd_en),
        .RdAddr_DI(rd_addr), .RdData_DO(rd_data_a), .RdValid_SO(rd_valid_a),
        .InitBusy_SO(busy_a)
    );

    sync_tp_ram_init #(
        .ADDR_WIDTH(AW), .DATA_DEPTH(DD), .DATA_WIDTH(DW),
        .OUT_REGS(0), .RDW_MODE(0), .INIT_VALUE(IV)
    ) dut_b (
        .Clk_CI(clk), .Rst_RI(rst), .WrEn_SI(wr_en), .WrAddr_DI(wr_addr),
        .WrData_DI(wr_data), .WrBe_DI(wr_be), .RdEn_SI(rd_en),
        .RdAddr_DI(rd_addr), .RdData_DO(rd_data_b), .RdValid_SO(rd_valid_b),
        .InitBusy_SO(busy_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Instance 0 = dut_a (latency 2, write-first), 1 = dut_b (latency 1, read-first).
    // A read sampled at edge e is delivered after edge e+lat-1.
    logic [31:0] mm [2][DD];
    int          init_left = 0;
    int          edge_n    = 0;
    logic        sv [2][4];
    logic [31:0] sd [2][4];
    logic        exp_v [2];
    logic [31:0] exp_d [2];
    logic        exp_busy;
    logic [31:0] r_tmp;
    int          slot;

    function automatic int extra_lat(input int k);
        return (k == 0) ? 1 : 0;
    endfunction

    always @(posedge clk) begin
        edge_n++;
        if (rst) begin
            init_left = DD;
            for (int k = 0; k < 2; k++) begin
                for (int s = 0; s < 4; s++) sv[k][s] = 1'b0;
                exp_v[k] = 1'b0;
                exp_d[k] = '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) exp_v[k] = 1'b0;
            if (init_left > 0) begin
                for (int k = 0; k < 2; k++) mm[k][DD - init_left] = IV;
                init_left--;
            end else begin
                if (rd_en) begin
                    for (int k = 0; k < 2; k++) begin
                        if (int'(rd_addr) >= DD) begin
                            r_tmp = '0;
                        end else begin
                            r_tmp = mm[k][rd_addr];
                            if (k == 0 && wr_en && wr_addr == rd_addr)
                                for (int b = 0; b < BW; b++)
                                    if (wr_be[b]) r_tmp[b*8 +: 8] = wr_data[b*8 +: 8];
                        end
                        slot = (edge_n + extra_lat(k)) % 4;
                        sv[k][slot] = 1'b1;
                        sd[k][slot] = r_tmp;
                    end
                end
                if (wr_en && int'(wr_addr) < DD)
                    for (int k = 0; k < 2; k++)
                        for (int b = 0; b < BW; b++)
                            if (wr_be[b]) mm[k][wr_addr][b*8 +: 8] = wr_data[b*8 +: 8];
            end
            for (int k = 0; k < 2; k++) begin
                slot = edge_n % 4;
                if (sv[k][slot]) begin
                    exp_v[k]    = 1'b1;
                    exp_d[k]    = sd[k][slot];
                    sv[k][slot] = 1'b0;
                end
            end
        end
        exp_busy = (init_left != 0);
    end

    // Cycle-by-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy_a",  {31'b0, busy_a},     {31'b0, exp_busy});
            check("busy_b",  {31'b0, busy_b},     {31'b0, exp_busy});
            check("valid_a", {31'b0, rd_valid_a}, {31'b0, exp_v[0]});
            check("valid_b", {31'b0, rd_valid_b}, {31'b0, exp_v[1]});
            check("data_a",  rd_data_a, exp_d[0]);
            check("data_b",  rd_data_b, exp_d[1]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; rd_en = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
    endtask

    task automatic do_write(input int a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = d; wr_be = be;
        step();
        wr_en = 1'b0;
    endtask

    task automatic count_init(input string tag);
        int cnt;
        cnt = 0;
        while (busy_a && cnt < 40) begin
            step();
            cnt++;
        end
        check(tag, cnt, DD);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        chk_en = 1'b1;
        rst = 1'b0;
        count_init("init_len");

        // Partial byte write over the init pattern
        do_write(5, 32'h11223344, 4'b0101);
        rd_en = 1'b1; rd_addr = 4'd5;
        step();
        rd_en = 1'b0;
        check("be_data_b",  rd_data_b, 32'hA522A544);
        check("be_valid_b", {31'b0, rd_valid_b}, 32'd1);
        step();
        check("be_data_a",  rd_data_a, 32'hA522A544);
        check("be_valid_a", {31'b0, rd_valid_a}, 32'd1);
        check("be_once_b",  {31'b0, rd_valid_b}, 32'd0);

        // Same-address read during write
        do_write(3, 32'h0, 4'hF);
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
        rd_en = 1'b1; rd_addr = 4'd3;
        step();
        wr_en = 1'b0;
        check("rdw_old_b", rd_data_b, 32'h0);
        step();
        rd_en = 1'b0;
        check("rdw_new_a", rd_data_a, 32'hFFFFFFFF);
        check("rdw_next_b", rd_data_b, 32'hFFFFFFFF);
        step();
        check("rdw_next_a", rd_data_a, 32'hFFFFFFFF);

        // Back-to-back reads through the two-stage pipeline
        do_write(0, 32'h100, 4'hF);
        do_write(1, 32'h101, 4'hF);
        do_write(2, 32'h102, 4'hF);
        rd_en = 1'b1; rd_addr = 4'd0;
        step();
        check("b2b_lat_a", {31'b0, rd_valid_a}, 32'd0);
        rd_addr = 4'd1;
        step();
        check("b2b0_a", rd_data_a, 32'h100);
        rd_addr = 4'd2;
        step();
        rd_en = 1'b0;
        check("b2b1_a", rd_data_a, 32'h101);
        check("b2b1_v", {31'b0, rd_valid_a}, 32'd1);
        step();
        check("b2b2_a", rd_data_a, 32'h102);
        step();
        check("b2b_end_v", {31'b0, rd_valid_a}, 32'd0);
        check("b2b_hold",  rd_data_a, 32'h102);

        // Out-of-range write and read
        do_write(13, 32'hDEADBEEF, 4'hF);
        rd_en = 1'b1; rd_addr = 4'd13;
        step();
        rd_en = 1'b0;
        check("oor_data_b",  rd_data_b, 32'h0);
        check("oor_valid_b", {31'b0, rd_valid_b}, 32'd1);
        for (int i = 0; i < DD; i++) begin
            rd_en = 1'b1; rd_addr = AW'(i);
            step();
        end
        rd_en = 1'b0;
        step();

        // Reset with a read in flight, then reset again at init count 7
        rd_en = 1'b1; rd_addr = 4'd0;
        step();
        rd_en = 1'b0; rst = 1'b1;
        step();
        check("abort_valid_a", {31'b0, rd_valid_a}, 32'd0);
        rst = 1'b0;
        repeat (7) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        count_init("init_len_restart");
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1; rd_addr = AW'(i);
            step();
        end
        rd_en = 1'b0;

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            rst     = ($urandom_range(0, 63) == 0);
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = AW'($urandom_range(0, 15));
            wr_data = $urandom;
            wr_be   = BW'($urandom_range(0, 15));
            rd_en   = 1'($urandom_range(0, 1));
            rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, 15));
            step();
        end
        rst = 1'b0;
        idle_inputs();
        begin
            int w;
            w = 0;
            while (busy_a && w < 40) begin
                step();
                w++;
            end
            check("ready_timeout", {31'b0, busy_a}, 32'd0);
        end
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1; rd_addr = AW'(i);
            step();
        end
        rd_en = 1'b0;
        repeat (3) step();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_tp_ram_init.md
SYNC_TP_RAM_INIT -- requirements
Module: sync_tp_ram_init

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10: address width.
REQ-002 SHALL have parameter DATA_DEPTH, default 1024: number of words, <= 2**ADDR_WIDTH.
REQ-003 SHALL have parameter DATA_WIDTH, default 32: word width, multiple of 8.
REQ-004 SHALL have parameter OUT_REGS, default 0: 0 or 1 extra read output register stage.
REQ-005 SHALL have parameter RDW_MODE, default 0: 0 = read-first (old data), 1 = write-first (forwarded new data).
REQ-006 SHALL have parameter INIT_VALUE, default '0: DATA_WIDTH-bit value written to every word after reset.
REQ-007 SHALL use one clock and a synchronous, active-high reset; all state changes on the rising edge of Clk_CI.
REQ-008 Clk_CI  input  1  clock.
REQ-009 Rst_RI  input  1  synchronous active-high reset.
REQ-010 WrEn_SI  input  1  write request.
REQ-011 WrAddr_DI  input  ADDR_WIDTH  write address.
REQ-012 WrData_DI  input  DATA_WIDTH  write data.
REQ-013 WrBe_DI  input  DATA_WIDTH/8  byte enables; bit i covers WrData_DI[8i+7:8i].
REQ-014 RdEn_SI  input  1  read request.
REQ-015 RdAddr_DI  input  ADDR_WIDTH  read address.
REQ-016 RdData_DO  output  DATA_WIDTH  read data.
REQ-017 RdValid_SO  output  1  one-cycle pulse, RdData_DO holds the data of a completed read.
REQ-018 InitBusy_SO  output  1  high while the init sequencer is filling memory.

Function
REQ-019 FSM SHALL have two states: INIT and READY; reset forces INIT with init counter = 0.
REQ-020 In INIT, each cycle SHALL write INIT_VALUE (all bytes) to address = counter, then increment; after writing DATA_DEPTH-1 the FSM SHALL enter READY next cycle.
REQ-021 Init SHALL take exactly DATA_DEPTH cycles after the last reset cycle; InitBusy_SO high for all of them, low from the first READY cycle.
REQ-022 In INIT, WrEn_SI and RdEn_SI SHALL be ignored: no user write, RdValid_SO stays 0.
REQ-023 In READY, WrEn_SI=1 SHALL update only bytes with WrBe_DI[i]=1 at WrAddr_DI; others unchanged; WrBe_DI=0 is a no-op.
REQ-024 Writes with WrAddr_DI >= DATA_DEPTH SHALL be dropped without side effect.
REQ-025 In READY, RdEn_SI=1 SHALL produce RdData_DO and RdValid_SO=1 exactly 1+OUT_REGS cycles later; reads are fully pipelined, one per cycle.
REQ-026 Reads with RdAddr_DI >= DATA_DEPTH SHALL return all zeros with RdValid_SO=1.
REQ-027 RdData_DO SHALL hold its last value when no read completes.
REQ-028 Same-cycle read and write to the same address: RDW_MODE=0 returns pre-write word; RDW_MODE=1 returns the old word with enabled bytes replaced by WrData_DI.
REQ-029 Read and write to different addresses in the same cycle SHALL both complete independently.
REQ-030 DATA_DEPTH > 2**ADDR_WIDTH, DATA_WIDTH not multiple of 8, OUT_REGS not in {0,1} or RDW_MODE not in {0,1} SHALL cause an elaboration error.

Reset
REQ-031 While Rst_RI=1 at a clock edge: RdData_DO <= 0, RdValid_SO <= 0, InitBusy_SO <= 1, pipeline valid bits cleared, FSM <= INIT, counter <= 0.
REQ-032 Reset asserted mid-init or mid-read SHALL abort in-flight reads (no RdValid_SO pulse) and restart init from address 0.
REQ-033 Memory contents SHALL be defined only via the init sequence; no reset of the array itself.

Verification
REQ-034 Reset 1 cycle, DATA_DEPTH=16, INIT_VALUE=32'hA5A5A5A5 -> InitBusy_SO high exactly 16 cycles; then reading addresses 0..15 returns 32'hA5A5A5A5.
REQ-035 READY, write 32'h11223344 to addr 5 with WrBe=4'b0101 over init 0 -> read addr 5 returns 32'h00220044 after 1+OUT_REGS cycles with one RdValid_SO pulse.
REQ-036 Addr 3 holds 32'h0; same cycle write 32'hFFFFFFFF BE=4'hF and read addr 3 -> RDW_MODE=0 returns 32'h0, RDW_MODE=1 returns 32'hFFFFFFFF; next read returns 32'hFFFFFFFF in both.
REQ-037 Back-to-back reads addrs 0,1,2 with OUT_REGS=1 -> RdValid_SO high 3 consecutive cycles starting 2 cycles after the first request, data in order.
REQ-038 Reset asserted at init count 7, and with a read in flight -> no RdValid_SO pulse; InitBusy_SO stays high a full DATA_DEPTH cycles after reset release.
REQ-039 DATA_DEPTH=12, ADDR_WIDTH=4: write addr 13, read addr 13 -> RdData_DO=0, RdValid_SO=1, addresses 0..11 unchanged.
